video_bin_demodulator_core: RTL and testbench

- Inverse of the table-driven binary modulator. Integrates a stream of 1-bit binarized video frames back into a multi-level grayscale stream by accumulating each pixel's binary value over a window of param_end+1 frames.
- Sits after the binary video path (e.g. the camera/segmentation side). Feeds grayscale display or the MNIST input path over AXI4-Stream.
- Per-pixel accumulators are held in an internal simple-dual-port RAM using read-modify-write.

---
 rtl/video_bin_demodulator_core.sv | 239 +++++++++++++++++++++++
 tb/tb_video_bin_demodulator_core.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_bin_demodulator_core.sv
// Integrates a stream of 1-bit binarized video frames into per-pixel counts over a
// window of param_end+1 frames, using a read-modify-write accumulator RAM.
module video_bin_demodulator_core #(
    parameter int TUSER_BITS   = 1,
    parameter int ADDR_BITS    = 10,
    parameter int MEM_DEPTH    = 2 ** ADDR_BITS,
    parameter     RAM_TYPE     = "block",
    parameter int FRAME_BITS   = 6,
    parameter int SUM_BITS     = 8,
    parameter int M_SLAVE_REG  = 1,
    parameter int M_MASTER_REG = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  aclken,
    input  logic [FRAME_BITS-1:0] param_end,
    input  logic [TUSER_BITS-1:0] s_axi4s_tuser,
    input  logic                  s_axi4s_tlast,
    input  logic                  s_axi4s_tbinary,
    input  logic                  s_axi4s_tvalid,
    output logic                  s_axi4s_tready,
    output logic [TUSER_BITS-1:0] m_axi4s_tuser,
    output logic                  m_axi4s_tlast,
    output logic [SUM_BITS-1:0]   m_axi4s_tdata,
    output logic                  m_axi4s_tcomplete,
    output logic                  m_axi4s_tvalid,
    input  logic                  m_axi4s_tready
);

    typedef struct packed {
        logic                  valid;
        logic [TUSER_BITS-1:0] user;
        logic                  last;
        logic                  bin;
        logic [ADDR_BITS-1:0]  addr;
        logic                  active;
        logic                  first;
        logic                  complete;
    } ctrl_t;

    localparam int FW = TUSER_BITS + SUM_BITS + 2;

    logic                  cke_s;
    logic                  accept_s;
    logic                  ff_ready_s;
    logic [ADDR_BITS-1:0]  addr_r;
    logic [ADDR_BITS-1:0]  beat_addr_s;
    logic [FRAME_BITS-1:0] idx_r;
    logic [FRAME_BITS-1:0] idx_s;
    logic [FRAME_BITS-1:0] end_r;
    logic [FRAME_BITS-1:0] end_s;
    logic                  init_r;
    logic                  init_s;
    ctrl_t                 s0_r;
    ctrl_t                 s1_r;
    ctrl_t                 s2_r;
    logic [SUM_BITS-1:0]   q1_r;
    logic [SUM_BITS-1:0]   q2_r;
    logic [SUM_BITS:0]     sum_s;
    logic [SUM_BITS-1:0]   new_s;
    (* ram_style = RAM_TYPE *)
    logic [SUM_BITS-1:0]   mem_r [MEM_DEPTH];
    logic                  res_valid_r;
    logic [TUSER_BITS-1:0] res_user_r;
    logic                  res_last_r;
    logic [SUM_BITS-1:0]   res_data_r;
    logic                  res_complete_r;
    logic [FW-1:0]         in_data_s;
    logic [FW-1:0]         mid_data_s;
    logic [FW-1:0]         m_data_s;
    logic [FW-1:0]         skid_data_r;
    logic [FW-1:0]         out_data_r;
    logic                  mid_valid_s;
    logic                  mid_ready_s;
    logic                  m_valid_s;
    logic                  skid_valid_r;
    logic                  out_valid_r;

    assign cke_s    = ff_ready_s & aclken;
    assign accept_s = cke_s & s_axi4s_tvalid;

    // Address and frame-index bookkeeping for the beat currently offered
    always_comb begin
        idx_s       = idx_r;
        end_s       = end_r;
        init_s      = init_r;
        beat_addr_s = addr_r + ADDR_BITS'(1);
        if (accept_s && s_axi4s_tuser[0]) begin
            beat_addr_s = '0;
            init_s      = 1'b0;
            if (init_r || (idx_r == end_r)) begin
                idx_s = '0;
                end_s = param_end;
            end else begin
                idx_s = idx_r + FRAME_BITS'(1);
                end_s = end_r;
            end
        end else begin
            beat_addr_s = addr_r + ADDR_BITS'(1);
        end
    end

    // Counter state; INIT keeps pre-SOF beats out of the accumulators
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            addr_r <= '0;
            idx_r  <= '0;
            end_r  <= '0;
            init_r <= 1'b1;
        end else if (accept_s) begin
            addr_r <= beat_addr_s;
            idx_r  <= idx_s;
            end_r  <= end_s;
            init_r <= init_s;
        end
    end

    // Control pipeline stages 0..2 running alongside the RAM read latency
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s0_r <= '0;
            s1_r <= '0;
            s2_r <= '0;
        end else if (cke_s) begin
            s0_r.valid    <= s_axi4s_tvalid;
            s0_r.user     <= s_axi4s_tuser;
            s0_r.last     <= s_axi4s_tlast;
            s0_r.bin      <= s_axi4s_tbinary;
            s0_r.addr     <= beat_addr_s;
            s0_r.active   <= ~init_s;
            s0_r.first    <= (idx_s == '0);
            s0_r.complete <= (idx_s == end_s);
            s1_r          <= s0_r;
            s2_r          <= s1_r;
        end
    end

    // Accumulator update: restart on frame 0, otherwise saturating add
    always_comb begin
        sum_s = (SUM_BITS + 1)'(q2_r) + (SUM_BITS + 1)'(s2_r.bin);
        if (!s2_r.active) begin
            new_s = '0;
        end else if (s2_r.first) begin
            new_s = SUM_BITS'(s2_r.bin);
        end else if (sum_s[SUM_BITS]) begin
            new_s = '1;
        end else begin
            new_s = sum_s[SUM_BITS-1:0];
        end
    end

    // RAM write port
    always_ff @(posedge aclk) begin
        if (cke_s && s2_r.valid && s2_r.active) begin
            mem_r[s2_r.addr] <= new_s;
        end
    end

    // RAM read port with output register (two-cycle latency)
    always_ff @(posedge aclk) begin
        if (cke_s) begin
            q1_r <= mem_r[s0_r.addr];
            q2_r <= q1_r;
        end
    end

    // Result register feeding the output stream FF
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            res_valid_r    <= 1'b0;
            res_user_r     <= '0;
            res_last_r     <= 1'b0;
            res_data_r     <= '0;
            res_complete_r <= 1'b0;
        end else if (cke_s) begin
            res_valid_r    <= s2_r.valid;
            res_user_r     <= s2_r.user;
            res_last_r     <= s2_r.last;
            res_data_r     <= new_s;
            res_complete_r <= s2_r.active & s2_r.complete;
        end
    end

    assign in_data_s = {res_user_r, res_last_r, res_complete_r, res_data_r};

    // Output FF steering: optional skid (ready side) and output (data side) registers
    always_comb begin
        if (skid_valid_r) begin
            mid_valid_s = 1'b1;
            mid_data_s  = skid_data_r;
        end else begin
            mid_valid_s = res_valid_r;
            mid_data_s  = in_data_s;
        end
        if (M_MASTER_REG != 0) begin
            mid_ready_s = ~out_valid_r | m_axi4s_tready;
            m_valid_s   = out_valid_r;
            m_data_s    = out_data_r;
        end else begin
            mid_ready_s = m_axi4s_tready;
            m_valid_s   = mid_valid_s;
            m_data_s    = mid_data_s;
        end
        if (M_SLAVE_REG != 0) begin
            ff_ready_s = ~skid_valid_r;
        end else begin
            ff_ready_s = mid_ready_s;
        end
    end

    // Output FF registers; everything holds while aclken is low
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
        end else if (aclken) begin
            if (mid_ready_s) begin
                skid_valid_r <= 1'b0;
            end else if ((M_SLAVE_REG != 0) && res_valid_r && !skid_valid_r) begin
                skid_valid_r <= 1'b1;
                skid_data_r  <= in_data_s;
            end
            if ((M_MASTER_REG != 0) && mid_ready_s) begin
                out_valid_r <= mid_valid_s;
                out_data_r  <= mid_data_s;
            end
        end
    end

    assign s_axi4s_tready    = ff_ready_s;
    assign m_axi4s_tvalid    = m_valid_s;
    assign m_axi4s_tuser     = m_data_s[FW-1 -: TUSER_BITS];
    assign m_axi4s_tlast     = m_data_s[SUM_BITS+1];
    assign m_axi4s_tcomplete = m_data_s[SUM_BITS];
    assign m_axi4s_tdata     = m_data_s[SUM_BITS-1:0];

endmodule

// File: tb/tb_video_bin_demodulator_core.sv
// Directed bench for video_bin_demodulator_core: a default instance and a 2-bit-sum
// instance share one input stream; each scenario task checks the captured output beats.
module tb_video_bin_demodulator_core;

    typedef struct packed {
        logic       user;
        logic       last;
        logic       comp;
        logic [7:0] data;
    } beat_t;

    logic       aclk      = 1'b0;
    logic       aresetn   = 1'b0;
    logic       aclken    = 1'b1;
    logic [5:0] param_end = 6'd0;
    logic [0:0] s_tuser   = 1'b0;
    logic       s_tlast   = 1'b0;
    logic       s_tbin    = 1'b0;
    logic       s_tvalid  = 1'b0;
    logic       m_tready  = 1'b1;
    logic       rand_mode = 1'b0;

    logic       a_s_tready, a_m_tlast, a_m_tcomplete, a_m_tvalid;
    logic [0:0] a_m_tuser;
    logic [7:0] a_m_tdata;
    logic       b_s_tready, b_m_tlast, b_m_tcomplete, b_m_tvalid;
    logic [0:0] b_m_tuser;
    logic [1:0] b_m_tdata;

    beat_t qa[$];
    beat_t qb[$];
    beat_t ba, bb;
    int    vectors     = 0;
    int    miscompares = 0;

    video_bin_demodulator_core dut_a (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .param_end(param_end),
        .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tbinary(s_tbin),
        .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(a_s_tready),
        .m_axi4s_tuser(a_m_tuser), .m_axi4s_tlast(a_m_tlast), .m_axi4s_tdata(a_m_tdata),
        .m_axi4s_tcomplete(a_m_tcomplete), .m_axi4s_tvalid(a_m_tvalid),
        .m_axi4s_tready(m_tready)
    );

    video_bin_demodulator_core #(.SUM_BITS(2)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .param_end(param_end),
        .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tbinary(s_tbin),
        .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(b_s_tready),
        .m_axi4s_tuser(b_m_tuser), .m_axi4s_tlast(b_m_tlast), .m_axi4s_tdata(b_m_tdata),
        .m_axi4s_tcomplete(b_m_tcomplete), .m_axi4s_tvalid(b_m_tvalid),
        .m_axi4s_tready(m_tready)
    );

    always #5 aclk = ~aclk;

    // Output-side driver and monitor: both values hold until the next rising edge
    always @(negedge aclk) begin
        aclken   = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        m_tready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (aresetn && aclken && m_tready && a_m_tvalid) begin
            ba.user = a_m_tuser[0]; ba.last = a_m_tlast; ba.comp = a_m_tcomplete; ba.data = a_m_tdata;
            qa.push_back(ba);
        end
        if (aresetn && aclken && m_tready && b_m_tvalid) begin
            bb.user = b_m_tuser[0]; bb.last = b_m_tlast; bb.comp = b_m_tcomplete; bb.data = {6'd0, b_m_tdata};
            qb.push_back(bb);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge aclk); #1; end
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        aresetn  = 1'b0;
        tick(3);
        aresetn = 1'b1;
        tick(1);
        qa.delete();
        qb.delete();
    endtask

    task automatic send_beat(input logic sof, input logic last, input logic bin);
        int   budget = 0;
        logic acc;
        s_tuser = sof; s_tlast = last; s_tbin = bin; s_tvalid = 1'b1;
        do begin
            acc = a_s_tready && aclken;
            tick(1);
            budget++;
        end while (!acc && budget < 1000);
        if (!acc) begin
            vectors++; miscompares++;
            $display("FAIL send_beat: input not accepted, tready=%b required 1", a_s_tready);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input logic [63:0] bits);
        for (int p = 0; p < w * h; p++) send_beat(p == 0, (p % w) == (w - 1), bits[p]);
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (qa.size() < n && t < 20000) begin tick(1); t++; end
        tick(10);
    endtask

    task automatic test_reset();
        s_tvalid = 1'b0;
        aresetn  = 1'b0;
        tick(3);
        vectors++; if (a_m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid_a: got %b required 0", a_m_tvalid); end
        vectors++; if (b_m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid_b: got %b required 0", b_m_tvalid); end
        aresetn = 1'b1;
        tick(2);
        vectors++; if (a_s_tready !== 1'b1) begin miscompares++; $display("FAIL reset_tready_a: got %b required 1", a_s_tready); end
        vectors++; if (b_s_tready !== 1'b1) begin miscompares++; $display("FAIL reset_tready_b: got %b required 1", b_s_tready); end
        vectors++; if (a_m_tvalid !== 1'b0) begin miscompares++; $display("FAIL idle_tvalid: got %b required 0", a_m_tvalid); end
    endtask

    task automatic test_window_pre_sof();
        int          exp5[5] = '{1, 1, 2, 3, 0};
        int          exp2[5] = '{1, 2, 3, 4, 1};
        logic        pat5[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [63:0] bits;
        int          b;
        do_reset();
        param_end = 6'd3;
        for (int i = 0; i < 3; i++) send_beat(1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 5; f++) begin
            bits = 64'hFF; bits[5] = pat5[f];
            send_frame(4, 2, bits);
        end
        wait_out(43);
        vectors++;
        if (qa.size() != 43) begin
            miscompares++; $display("FAIL window_count: got %0d beats required 43", qa.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (qa[i].data !== 8'd0 || qa[i].comp !== 1'b0) begin
                    miscompares++; $display("FAIL pre_sof[%0d]: got data %0d comp %b required 0/0", i, qa[i].data, qa[i].comp);
                end
            end
            for (int f = 0; f < 5; f++) begin
                b = 3 + 8 * f;
                vectors++; if (qa[b+5].data !== 8'(exp5[f])) begin miscompares++; $display("FAIL pix5_f%0d: got %0d required %0d", f, qa[b+5].data, exp5[f]); end
                vectors++; if (qa[b+2].data !== 8'(exp2[f])) begin miscompares++; $display("FAIL pix2_f%0d: got %0d required %0d", f, qa[b+2].data, exp2[f]); end
                vectors++; if (qa[b].comp !== (f == 3)) begin miscompares++; $display("FAIL comp_f%0d: got %b required %b", f, qa[b].comp, (f == 3)); end
                vectors++; if (qa[b].user !== 1'b1 || qa[b+1].user !== 1'b0) begin miscompares++; $display("FAIL user_f%0d: got %b%b required 10", f, qa[b].user, qa[b+1].user); end
                vectors++; if (qa[b+7].last !== 1'b1 || qa[b+6].last !== 1'b0) begin miscompares++; $display("FAIL last_f%0d: got %b%b required 01", f, qa[b+6].last, qa[b+7].last); end
            end
        end
    endtask

    task automatic test_saturation();
        int expb[8] = '{1, 2, 3, 3, 3, 3, 3, 3};
        do_reset();
        param_end = 6'd7;
        for (int f = 0; f < 8; f++) send_frame(2, 2, 64'hF);
        wait_out(32);
        vectors++;
        if (qa.size() != 32 || qb.size() != 32) begin
            miscompares++; $display("FAIL sat_count: got %0d/%0d beats required 32/32", qa.size(), qb.size());
        end else begin
            for (int f = 0; f < 8; f++) begin
                vectors++; if (qb[4*f+3].data !== 8'(expb[f])) begin miscompares++; $display("FAIL sat_b_f%0d: got %0d required %0d", f, qb[4*f+3].data, expb[f]); end
                vectors++; if (qb[4*f+3].comp !== (f == 7)) begin miscompares++; $display("FAIL sat_comp_f%0d: got %b required %b", f, qb[4*f+3].comp, (f == 7)); end
                vectors++; if (qa[4*f+3].data !== 8'(f + 1)) begin miscompares++; $display("FAIL nosat_a_f%0d: got %0d required %0d", f, qa[4*f+3].data, f + 1); end
            end
        end
    endtask

    task automatic test_param_change();
        int   expd[7] = '{1, 2, 3, 4, 1, 2, 1};
        logic expc[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        param_end = 6'd3;
        for (int f = 0; f < 7; f++) begin
            for (int p = 0; p < 4; p++) begin
                if (f == 2 && p == 1) param_end = 6'd1;
                send_beat(p == 0, p[0], 1'b1);
            end
        end
        wait_out(28);
        vectors++;
        if (qa.size() != 28) begin
            miscompares++; $display("FAIL pchg_count: got %0d beats required 28", qa.size());
        end else begin
            for (int f = 0; f < 7; f++) begin
                vectors++; if (qa[4*f+1].data !== 8'(expd[f])) begin miscompares++; $display("FAIL pchg_data_f%0d: got %0d required %0d", f, qa[4*f+1].data, expd[f]); end
                vectors++; if (qa[4*f+1].comp !== expc[f]) begin miscompares++; $display("FAIL pchg_comp_f%0d: got %b required %b", f, qa[4*f+1].comp, expc[f]); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] bits_a = 8'b1010_0110;
        do_reset();
        param_end = 6'd3;
        send_frame(4, 2, 64'hFF);
        for (int p = 0; p < 3; p++) send_beat(p == 0, 1'b0, 1'b1);
        tick(2);
        do_reset();
        param_end = 6'd1;
        send_frame(4, 2, {56'd0, bits_a});
        send_frame(4, 2, 64'hFF);
        send_frame(4, 2, 64'h0);
        wait_out(24);
        vectors++;
        if (qa.size() != 24) begin
            miscompares++; $display("FAIL rmid_count: got %0d beats required 24", qa.size());
        end else begin
            for (int p = 0; p < 8; p++) begin
                vectors++;
                if (qa[p].data !== {7'd0, bits_a[p]} || qa[p].comp !== 1'b0) begin
                    miscompares++; $display("FAIL rmid_f0_p%0d: got %0d/%b required %0d/0", p, qa[p].data, qa[p].comp, bits_a[p]);
                end
                vectors++;
                if (qa[8+p].data !== 8'(bits_a[p] + 1) || qa[8+p].comp !== 1'b1) begin
                    miscompares++; $display("FAIL rmid_f1_p%0d: got %0d/%b required %0d/1", p, qa[8+p].data, qa[8+p].comp, bits_a[p] + 1);
                end
                vectors++;
                if (qa[16+p].data !== 8'd0) begin
                    miscompares++; $display("FAIL rmid_f2_p%0d: got %0d required 0", p, qa[16+p].data);
                end
            end
        end
    endtask

    task automatic test_back_to_back_random();
        beat_t       expq[$];
        beat_t       e;
        int          acc[64];
        logic [63:0] bits;
        int          n;
        do_reset();
        param_end = 6'd2;
        rand_mode = 1'b1;
        for (int f = 0; f < 4; f++) begin
            bits = {$urandom(), $urandom()};
            for (int p = 0; p < 64; p++) begin
                if (f % 3 == 0) acc[p] = int'(bits[p]);
                else            acc[p] = acc[p] + int'(bits[p]);
                e.user = (p == 0); e.last = (p % 8 == 7); e.comp = (f % 3 == 2); e.data = 8'(acc[p]);
                expq.push_back(e);
            end
            send_frame(8, 8, bits);
        end
        wait_out(256);
        rand_mode = 1'b0;
        tick(2);
        n = (qa.size() < expq.size()) ? qa.size() : expq.size();
        vectors++;
        if (qa.size() != expq.size()) begin
            miscompares++; $display("FAIL rand_count: got %0d beats required %0d", qa.size(), expq.size());
        end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (qa[i] !== expq[i]) begin
                miscompares++;
                $display("FAIL rand_beat[%0d]: got u%b l%b c%b d%0d required u%b l%b c%b d%0d", i,
                         qa[i].user, qa[i].last, qa[i].comp, qa[i].data,
                         expq[i].user, expq[i].last, expq[i].comp, expq[i].data);
            end
        end
    endtask

    initial begin
        @(negedge aclk); #1;
        test_reset();
        test_window_pre_sof();
        test_saturation();
        test_param_change();
        test_reset_mid_frame();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
